// File: rtl/mfda_seq_pkg.sv
// Shared types and tree-geometry helpers for the mixing-tree valve sequencer.
package mfda_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        MIX   = 2'd2,
        DRAIN = 2'd3
    } seq_state_t;

    function automatic int levels(input int n_leaf);
        return $clog2(n_leaf);
    endfunction

    // Heap level lvl spans nodes n_leaf>>(lvl+1) .. (n_leaf>>lvl)-1.
    function automatic logic node_in_level(input int n_leaf, input int lvl, input int node);
        return (node >= (n_leaf >> (lvl + 1))) && (node <= ((n_leaf >> lvl) - 1));
    endfunction

endpackage

// File: rtl/mix_tree_sequencer_dwell_timer.sv
// Phase dwell down-counter: load with (cycles - 1), expire while the count is zero.
module dwell_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (load)
            cnt_q <= load_val;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - CNT_W'(1);
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/mix_tree_sequencer.sv
// Valve sequencer for a binary mixing tree: timed fill, level-by-level mix, drain.
// state | meaning
// IDLE  | waiting for start; done/aborted/err pulses appear here
// FILL  | leaf inlet valves open for the latched mask
// MIX   | active mixers of the current level open
// DRAIN | outlet valve open
module mix_tree_sequencer
    import mfda_seq_pkg::*;
#(
    parameter int N_LEAF       = 16,
    parameter int FILL_CYCLES  = 4,
    parameter int MIX_CYCLES   = 8,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [N_LEAF-1:0]            leaf_mask,
    output logic [N_LEAF-1:0]            fill_valve,
    output logic [N_LEAF-2:0]            mix_valve,
    output logic                         out_valve,
    output logic [levels(N_LEAF)-1:0]    level,
    output logic                         busy,
    output logic                         done,
    output logic                         aborted,
    output logic                         err
);

    localparam int LW = levels(N_LEAF);
    localparam logic [LW-1:0] LAST_LEVEL = LW'(levels(N_LEAF) - 1);

    seq_state_t        state_q, state_d;
    logic [LW-1:0]     level_d;
    logic [N_LEAF-1:0] mask_q, mask_d;
    logic              tmr_load, tmr_expire;
    logic [CNT_W-1:0]  tmr_val;
    logic              done_d, aborted_d, err_d;
    logic [N_LEAF-2:0] lvl_mask;
    logic [2*N_LEAF-1:1] act;

    dwell_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    // A node is active when any leaf beneath it is enabled.
    assign act[2*N_LEAF-1:N_LEAF] = mask_q;
    for (genvar i = 1; i < N_LEAF; i++) begin : g_act
        assign act[i] = act[2*i] | act[2*i+1];
    end

    always_comb begin
        lvl_mask = '0;
        for (int i = 1; i < N_LEAF; i++)
            lvl_mask[i-1] = act[i] & node_in_level(N_LEAF, int'(level_d), i);
    end

    always_comb begin
        state_d   = state_q;
        level_d   = level;
        mask_d    = mask_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        err_d     = 1'b0;
        if (state_q == IDLE) begin
            if (start && leaf_mask != '0) begin
                mask_d   = leaf_mask;
                state_d  = FILL;
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(FILL_CYCLES - 1);
            end else if (start) begin
                err_d = 1'b1;
            end
        end else if (abort) begin
            state_d   = IDLE;
            level_d   = '0;
            aborted_d = 1'b1;
        end else if (tmr_expire) begin
            tmr_load = 1'b1;
            case (state_q)
                FILL: begin
                    state_d = MIX;
                    level_d = '0;
                    tmr_val = CNT_W'(MIX_CYCLES - 1);
                end
                MIX: begin
                    if (level == LAST_LEVEL) begin
                        state_d = DRAIN;
                        level_d = '0;
                        tmr_val = CNT_W'(DRAIN_CYCLES - 1);
                    end else begin
                        level_d = level + LW'(1);
                        tmr_val = CNT_W'(MIX_CYCLES - 1);
                    end
                end
                default: begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    tmr_load = 1'b0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            level      <= '0;
            mask_q     <= '0;
            fill_valve <= '0;
            mix_valve  <= '0;
            out_valve  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            level      <= level_d;
            mask_q     <= mask_d;
            fill_valve <= (state_d == FILL) ? mask_d : '0;
            mix_valve  <= (state_d == MIX) ? lvl_mask : '0;
            out_valve  <= (state_d == DRAIN);
            busy       <= (state_d != IDLE);
            done       <= done_d;
            aborted    <= aborted_d;
            err        <= err_d;
        end
    end

endmodule

// File: doc/mix_tree_sequencer.md
Name: mix_tree_sequencer

Overview:
- Clocked valve-control sequencer for a parametrised binary mixing tree: N_LEAF source chambers feed N_LEAF-1 pairwise mixers, reduced level by level to one outlet.
- Drives fill valves, per-mixer valves and an outlet valve through timed fill, mix-level and drain phases.
- New relative to fixed netlists: leaf count is a parameter, a runtime leaf mask selects which chambers take part, phase dwell times are programmable, and a run can be aborted.
- Sits between the host control interface and the valve driver array of generated MFDA chips.

Parameters:
- N_LEAF, 16, number of leaf chambers; power of two, 2..64.
- FILL_CYCLES, 4, clock cycles the fill valves stay open; must be >=1.
- MIX_CYCLES, 8, dwell cycles per mixer level; must be >=1.
- DRAIN_CYCLES, 2, cycles the outlet valve stays open; must be >=1.
- CNT_W, 16, dwell counter width; must hold the largest cycle parameter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle run request; sampled only in IDLE.
- abort  in  1  cancels an active run.
- leaf_mask  in  N_LEAF  enabled leaf chambers; latched at accepted start.
- fill_valve  out  N_LEAF  per-leaf inlet valve.
- mix_valve  out  N_LEAF-1  per-mixer valve; bit i-1 controls heap node i.
- out_valve  out  1  outlet valve.
- level  out  clog2(N_LEAF)  current mix level; 0 = deepest.
- busy  out  1  high in FILL, MIX and DRAIN.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse when a run is aborted.
- err  out  1  one-cycle pulse when start is rejected because leaf_mask == 0.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. While rst is high, the state returns to IDLE and all outputs, counters and the latched mask go to 0.
- Output timing: all outputs are registered Moore outputs.
- Tree indexing: heap layout. Mixer nodes are 1..N_LEAF-1. Node i has children 2i and 2i+1. Leaf j is node N_LEAF+j. Level k holds nodes N_LEAF>>(k+1) .. (N_LEAF>>k)-1. L = clog2(N_LEAF) levels.
- Node activity: a node is active if any leaf under it has its bit set in the latched mask. A node with one active child still opens; it acts as a pass-through.
- FSM states: IDLE, FILL, MIX, DRAIN.
- IDLE:
  - start=1 with leaf_mask!=0: latch mask, load counter, go to FILL next cycle.
  - start=1 with leaf_mask==0: pulse err next cycle, stay in IDLE.
- FILL: fill_valve = latched mask for exactly FILL_CYCLES cycles, then MIX with level=0.
- MIX:
  - mix_valve has the active nodes of the current level set; all other bits are 0.
  - Each level lasts exactly MIX_CYCLES cycles.
  - After the last cycle of a level, level increments. After level L-1 completes, go to DRAIN.
- DRAIN: out_valve=1 for DRAIN_CYCLES cycles, then IDLE. done pulses in the first IDLE cycle.
- Valve exclusivity: at most one valve group is open in any cycle. Phase changes have no overlap and no gap cycle.
- busy: 1 from the first FILL cycle through the last DRAIN cycle. Total busy = FILL_CYCLES + L*MIX_CYCLES + DRAIN_CYCLES.
- start while busy: ignored. Changing leaf_mask mid-run has no effect.
- abort while busy:
  - Next cycle: all valves 0, IDLE, aborted=1, no done.
  - abort in IDLE is ignored.
  - abort and start in the same IDLE cycle: start is taken.
- Precedence: rst > abort > dwell expiry.
- Counter: down-counter loaded with the parameter minus 1; the phase ends when the count reaches 0. No wrap-around is possible.

Decomposition:
- Package mfda_seq_pkg holds:
  - the state enum (IDLE/FILL/MIX/DRAIN);
  - a clog2-based LEVELS constant function;
  - a node-level-range helper function.
- One sub-module, dwell_timer (CNT_W-bit load/decrement, with an expire flag), shared by all phases.
- Node activity masks are computed combinationally from the latched mask by a generate OR-reduction over the tree.

Test Plan:
- Full run: defaults, mask=16'hFFFF, start pulse → fill_valve=FFFF for 4 cycles; mix_valve=7F80, 0078, 0006, 0001 for 8 cycles each; out_valve for 2 cycles; done at cycle 39 after the start cycle; busy high for exactly 38 cycles.
- Partial mask: mask=16'h0003 → fill_valve=0003; level 0 opens node 8 only (mix_valve=0080); then node 4 (0008), node 2 (0002), node 1 (0001).
- Zero mask: start with leaf_mask=0 → err pulse one cycle later; busy stays 0; all valves 0.
- Abort: abort in the 3rd cycle of level 1 → next cycle all valves 0, aborted=1, busy=0, no done; a following start runs a complete sequence.
- Sync reset mid-DRAIN: rst=1 for one cycle → all outputs 0 on the next edge, IDLE; no done pulse.
- Parameter sweep: N_LEAF=2, all cycle parameters =1, mask=2'b10 → fill 1 cycle, mix_valve=1 for 1 cycle, drain 1 cycle, done on the 4th cycle after start; start asserted while busy is ignored.
